// File: rtl/servo_ramp_scheduler.sv
// servo_ramp_scheduler: multi-channel servo duty ramp controller.
// A free-running tick counter starts a scan in which one shared slew engine
// steps each channel's current duty toward its target, one channel per cycle.
// Optional feature macro: SERVO_CLAMP_EN saturates commanded duties to
// [DUTY_MIN, DUTY_MAX] before they are stored as targets.
module servo_ramp_scheduler #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned DUTY_W     = 20,
  parameter int unsigned GAP_W      = 12,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DUTY_RESET = 75000,
  parameter int unsigned DUTY_MIN   = 25000,
  parameter int unsigned DUTY_MAX   = 125000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_ch,
  input  logic [DUTY_W-1:0]        cmd_duty,
  input  logic [GAP_W-1:0]         cmd_gap,
  output logic [CH_NUM*DUTY_W-1:0] duty_out,
  output logic [CH_NUM-1:0]        busy,
  output logic                     all_done
);

  localparam int unsigned IDX_W = $clog2(CH_NUM);
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned EXT_W = DUTY_W + 1;

  localparam logic [DUTY_W-1:0] RST_D    = DUTY_W'(DUTY_RESET);
  localparam logic [DUTY_W-1:0] MIN_D    = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(CH_NUM - 1);

`ifdef SERVO_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [CH_NUM-1:0] busy_q, busy_d;
  logic              all_done_q, all_done_d;

  logic [DUTY_W-1:0] cur_q [CH_NUM];
  logic [DUTY_W-1:0] cur_d [CH_NUM];
  logic [DUTY_W-1:0] tgt_q [CH_NUM];
  logic [DUTY_W-1:0] tgt_d [CH_NUM];
  logic [GAP_W-1:0]  gap_q [CH_NUM];
  logic [GAP_W-1:0]  gap_d [CH_NUM];

  logic              tick_c;
  logic              scan_en_c;
  logic              cmd_take_c;
  logic [DUTY_W-1:0] cmd_duty_c;
  logic [DUTY_W-1:0] cur_sel_c;
  logic [DUTY_W-1:0] tgt_sel_c;
  logic [GAP_W-1:0]  gap_sel_c;
  logic [DUTY_W-1:0] new_duty_c;
  logic [EXT_W-1:0]  cur_x, tgt_x, gap_x, diff_x, step_x, nxt_x;

  // Tick counter: free-runs 0..TICK_DIV-1, tick on the last count.
  always_comb begin
    tick_c = (cnt_q == CNT_LAST);
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state: idle until tick, walk every channel, one settle cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (tick_c) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: slew engine enable now, ready registered from next state.
  always_comb begin
    scan_en_c   = (state_q == S_SCAN);
    cmd_ready_d = (state_d == S_IDLE);
  end

  // Command acceptance with optional saturation of the requested duty.
  always_comb begin
    cmd_take_c = cmd_valid && cmd_ready_q;
    cmd_duty_c = cmd_duty;
    if (CLAMP_EN) begin
      if (cmd_duty < MIN_D) begin
        cmd_duty_c = MIN_D;
      end else if (cmd_duty > MAX_D) begin
        cmd_duty_c = MAX_D;
      end
    end
  end

  // Channel mux feeding the shared slew engine.
  always_comb begin
    cur_sel_c = '0;
    tgt_sel_c = '0;
    gap_sel_c = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_sel_c = cur_q[i];
        tgt_sel_c = tgt_q[i];
        gap_sel_c = gap_q[i];
      end
    end
  end

  // Slew engine: move toward target by at most gap, one bit of headroom.
  always_comb begin
    cur_x  = EXT_W'(cur_sel_c);
    tgt_x  = EXT_W'(tgt_sel_c);
    gap_x  = EXT_W'(gap_sel_c);
    diff_x = '0;
    step_x = '0;
    nxt_x  = cur_x;
    if (gap_sel_c == '0) begin
      nxt_x = tgt_x;
    end else if (cur_x < tgt_x) begin
      diff_x = tgt_x - cur_x;
      step_x = (gap_x < diff_x) ? gap_x : diff_x;
      nxt_x  = cur_x + step_x;
    end else if (cur_x > tgt_x) begin
      diff_x = cur_x - tgt_x;
      step_x = (gap_x < diff_x) ? gap_x : diff_x;
      nxt_x  = cur_x - step_x;
    end
    new_duty_c = DUTY_W'(nxt_x);
  end

  // Channel next state: scanned channel takes the new duty, command writes target/gap.
  always_comb begin
    for (int i = 0; i < int'(CH_NUM); i++) begin
      cur_d[i]  = cur_q[i];
      tgt_d[i]  = tgt_q[i];
      gap_d[i]  = gap_q[i];
      busy_d[i] = (cur_q[i] != tgt_q[i]);
      if (scan_en_c && (idx_q == IDX_W'(i))) begin
        cur_d[i] = new_duty_c;
      end
      if (cmd_take_c && (cmd_ch == 3'(i))) begin
        tgt_d[i] = cmd_duty_c;
        gap_d[i] = cmd_gap;
      end
    end
    all_done_d = ~|busy_d;
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= '0;
      all_done_q  <= 1'b1;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        cur_q[i] <= RST_D;
        tgt_q[i] <= RST_D;
        gap_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      all_done_q  <= all_done_d;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        cur_q[i] <= cur_d[i];
        tgt_q[i] <= tgt_d[i];
        gap_q[i] <= gap_d[i];
      end
    end
  end

  // Output packing, channel 0 in the LSBs.
  for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_pack
    assign duty_out[g*DUTY_W +: DUTY_W] = cur_q[g];
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign all_done  = all_done_q;

endmodule
